// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Contents: 64-bit register type, fetch FSM states, the NOP word carried by
// fault entries, the fetch-buffer entry layout, and a helper that builds
// one buffer entry.
`timescale 1ns/1ps
package if_stage_pkg;

  typedef logic [63:0] reg_t;

  localparam reg_t        DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } if_state_e;

  // 97-bit fetch buffer entry: {pc, inst, exc}
  typedef struct packed {
    reg_t        pc;
    logic [31:0] inst;
    logic        exc;
  } if_entry_t;

  function automatic if_entry_t make_entry(input reg_t pc, input logic [31:0] inst,
                                           input logic exc);
    if_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.exc  = exc;
    return e;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle for the fetch stage: instruction-RAM request/response, redirect
// from execute, and the valid/ready handshake toward decode.
// master: the fetch stage's view. slave: the environment (RAM, execute, decode).
`timescale 1ns/1ps
interface if_stage_if;
  import if_stage_pkg::*;

  reg_t        inst_addr;
  logic        inst_ena;
  logic [31:0] inst;
  logic        inst_ready;
  logic        redirect_valid;
  reg_t        redirect_pc;
  logic        id_valid;
  logic        id_ready;
  reg_t        id_pc;
  logic [31:0] id_inst;
  logic        id_exc;

  modport master (
    output inst_addr, inst_ena, id_valid, id_pc, id_inst, id_exc,
    input  inst, inst_ready, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  inst_addr, inst_ena, id_valid, id_pc, id_inst, id_exc,
    output inst, inst_ready, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fifo.sv
// Fetch buffer: DEPTH-entry circular FIFO (DEPTH a power of two) with
// synchronous flush. Head entry is presented combinationally.
// Ports: clk, rst_n (async active-low), i_flush, i_push, i_pop, i_data,
//        o_head, o_count, o_full, o_empty.
`timescale 1ns/1ps
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 97,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Push while full is legal only alongside a pop: the tail slot is the
      // head slot being read out this same cycle.
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (i_pop) r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to the instruction
// RAM port, buffers fetched words toward decode, and applies redirects from
// execute (which flush all in-flight fetch state).
// Ports: clk, rst_n (async active-low), bus (if_stage_if.master: RAM port,
//        redirect input, decode handshake).
`timescale 1ns/1ps
module if_stage
  import if_stage_pkg::*;
#(
  parameter reg_t        RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  if_stage_if.master    bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e     r_state;
  reg_t          r_pc;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  if_entry_t     w_head;
  if_entry_t     w_push_entry;
  logic          w_redirect;
  logic          w_aligned;
  logic          w_space;
  logic          w_fetch;
  logic          w_push;
  logic          w_pop;

  assign w_redirect = bus.redirect_valid;
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  // A flush discards the head, so a decode accept during redirect is not a pop.
  assign w_pop      = !w_empty && bus.id_ready && !w_redirect;
  assign w_space    = !w_full || (!w_empty && bus.id_ready);
  assign w_fetch    = (r_state == S_FETCH) && !w_redirect && w_space;
  // A misaligned PC pushes its fault entry without touching the RAM.
  assign w_push     = w_fetch && (!w_aligned || bus.inst_ready);

  always_comb begin
    w_push_entry = make_entry(r_pc, bus.inst, 1'b0);
    if (!w_aligned) w_push_entry = make_entry(r_pc, INST_NOP, 1'b1);
  end

  assign bus.inst_addr = r_pc;
  assign bus.inst_ena  = w_fetch && w_aligned;
  assign bus.id_valid  = (w_count != '0);
  assign bus.id_pc     = w_head.pc;
  assign bus.id_inst   = w_head.inst;
  assign bus.id_exc    = w_head.exc;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(if_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
    end else if (w_redirect) begin
      r_state <= S_FETCH;
      r_pc    <= bus.redirect_pc;
    end else begin
      unique case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: begin
          if (w_space) begin
            if (!w_aligned)          r_state <= S_FAULT;
            else if (bus.inst_ready) r_pc    <= r_pc + 64'd4;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  localparam reg_t RPC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  if_entry_t exp_q[$];

  if_stage_if u_if ();

  if_stage #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word content derived from the address
  function automatic logic [31:0] ramw(input reg_t a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  assign u_if.inst = ramw(u_if.inst_addr);

  function automatic if_entry_t mk(input reg_t pc, input logic exc);
    if_entry_t e;
    e.pc   = pc;
    e.inst = exc ? 32'h0000_0013 : ramw(pc);
    e.exc  = exc;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Check request outputs 3ns after the active edge.
  task automatic req(input string nm, input logic ena, input reg_t addr);
    #2;
    chk({nm, "_ena"}, 64'(u_if.inst_ena), 64'(ena));
    chk({nm, "_addr"}, u_if.inst_addr, addr);
  endtask

  // Monitor: every accepted decode handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && u_if.id_valid && u_if.id_ready && !u_if.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop got_pc=%h exp=none", u_if.id_pc);
      end else begin
        if_entry_t e;
        e = exp_q.pop_front();
        checks++;
        if (u_if.id_pc !== e.pc || u_if.id_inst !== e.inst || u_if.id_exc !== e.exc) begin
          failures++;
          $display("FAIL pop_entry got=%h/%h/%b exp=%h/%h/%b",
                   u_if.id_pc, u_if.id_inst, u_if.id_exc, e.pc, e.inst, e.exc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    u_if.inst_ready     = 1'b1;
    u_if.id_ready       = 1'b1;
    u_if.redirect_valid = 1'b0;
    u_if.redirect_pc    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", 64'(u_if.id_valid), 64'd0);
    chk("rst_ena", 64'(u_if.inst_ena), 64'd0);
    chk("rst_addr", u_if.inst_addr, RPC);
    chk("rst_id_pc", u_if.id_pc, 64'd0);
    chk("rst_id_inst", 64'(u_if.id_inst), 64'd0);
    chk("rst_id_exc", 64'(u_if.id_exc), 64'd0);

    // release: one boot cycle without request
    rst_n = 1'b1;
    req("boot", 1'b0, RPC);

    // streaming fetch
    for (int i = 0; i < 4; i++) begin
      nxt();
      exp_q.push_back(mk(RPC + 64'(4 * i), 1'b0));
      if (i == 0) chk("first_no_valid", 64'(u_if.id_valid), 64'd0);
      req("stream", 1'b1, RPC + 64'(4 * i));
    end

    // decode stall: buffer fills, then requests stop
    nxt(); u_if.id_ready = 1'b0;
    exp_q.push_back(mk(RPC + 64'h10, 1'b0));
    req("stall_fill", 1'b1, RPC + 64'h10);
    for (int k = 0; k < 4; k++) begin
      nxt();
      req("stall_full", 1'b0, RPC + 64'h14);
      chk("stall_head_pc", u_if.id_pc, RPC + 64'hC);
      chk("stall_valid", 64'(u_if.id_valid), 64'd1);
    end

    // release: full buffer with pop still allows a push
    nxt(); u_if.id_ready = 1'b1;
    exp_q.push_back(mk(RPC + 64'h14, 1'b0));
    req("resume", 1'b1, RPC + 64'h14);
    nxt(); exp_q.push_back(mk(RPC + 64'h18, 1'b0)); req("resume", 1'b1, RPC + 64'h18);
    nxt(); exp_q.push_back(mk(RPC + 64'h1C, 1'b0)); req("resume", 1'b1, RPC + 64'h1C);

    // RAM not ready: request held
    for (int k = 0; k < 3; k++) begin
      nxt(); u_if.inst_ready = 1'b0;
      req("ram_wait", 1'b1, RPC + 64'h20);
    end
    nxt(); u_if.inst_ready = 1'b1;
    exp_q.push_back(mk(RPC + 64'h20, 1'b0));
    req("ram_ack", 1'b1, RPC + 64'h20);
    nxt(); exp_q.push_back(mk(RPC + 64'h24, 1'b0)); req("pre_redir", 1'b1, RPC + 64'h24);
    nxt(); u_if.id_ready = 1'b0;
    exp_q.push_back(mk(RPC + 64'h28, 1'b0));
    req("pre_redir", 1'b1, RPC + 64'h28);

    // redirect with two entries buffered; decode accept is ignored
    nxt();
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = RPC + 64'h100;
    u_if.id_ready       = 1'b1;
    exp_q.delete();
    req("redir", 1'b0, RPC + 64'h2C);
    chk("redir_full_valid", 64'(u_if.id_valid), 64'd1);
    nxt(); u_if.redirect_valid = 1'b0;
    exp_q.push_back(mk(RPC + 64'h100, 1'b0));
    req("after_redir", 1'b1, RPC + 64'h100);
    chk("flush_empty", 64'(u_if.id_valid), 64'd0);
    nxt(); exp_q.push_back(mk(RPC + 64'h104, 1'b0)); req("after_redir", 1'b1, RPC + 64'h104);

    // misaligned redirect target
    nxt();
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = RPC + 64'h102;
    exp_q.delete();
    req("redir_mis", 1'b0, RPC + 64'h108);
    nxt(); u_if.redirect_valid = 1'b0;
    exp_q.push_back(mk(RPC + 64'h102, 1'b1));
    req("misalign", 1'b0, RPC + 64'h102);
    for (int k = 0; k < 3; k++) begin
      nxt();
      req("fault_hold", 1'b0, RPC + 64'h102);
    end
    nxt();
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = RPC + 64'h200;
    req("fault_redir", 1'b0, RPC + 64'h102);
    nxt(); u_if.redirect_valid = 1'b0;
    exp_q.push_back(mk(RPC + 64'h200, 1'b0));
    req("fault_exit", 1'b1, RPC + 64'h200);
    nxt(); exp_q.push_back(mk(RPC + 64'h204, 1'b0)); req("fault_exit", 1'b1, RPC + 64'h204);
    nxt(); u_if.id_ready = 1'b0;
    exp_q.push_back(mk(RPC + 64'h208, 1'b0));
    req("pre_reset", 1'b1, RPC + 64'h208);
    nxt();
    req("pre_reset_full", 1'b0, RPC + 64'h20C);

    // asynchronous reset mid-stream with full buffer
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("areset_valid", 64'(u_if.id_valid), 64'd0);
    chk("areset_ena", 64'(u_if.inst_ena), 64'd0);
    chk("areset_addr", u_if.inst_addr, RPC);
    nxt();
    nxt(); rst_n = 1'b1; u_if.id_ready = 1'b1;
    req("reboot", 1'b0, RPC);
    nxt(); exp_q.push_back(mk(RPC, 1'b0)); req("restart", 1'b1, RPC);
    nxt(); exp_q.push_back(mk(RPC + 64'h4, 1'b0)); req("restart", 1'b1, RPC + 64'h4);

    // PC wrap at the top of the address space
    nxt();
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_q.delete();
    req("wrap_redir", 1'b0, RPC + 64'h8);
    nxt(); u_if.redirect_valid = 1'b0;
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
    req("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt(); exp_q.push_back(mk(64'h0, 1'b0)); req("wrap_zero", 1'b1, 64'h0);
    nxt(); exp_q.push_back(mk(64'h4, 1'b0)); req("wrap_four", 1'b1, 64'h4);
    nxt(); u_if.inst_ready = 1'b0; req("drain", 1'b1, 64'h8);
    nxt();
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
